bridge_sequencer: RTL and testbench

- Central controller for the four-leg H-bridge power stage.
- Takes the strobed 3-bit command bus (I_C/I_CLK) and the active-low error inputs.
- Sequences mains precharge (FAN/CHARGE/ST), applies gate patterns with dead-time insertion, runs the armed discharge sequence and latches faults.
- Sits between the board pins and the gate/contactor outputs; the UART status reporter reads its state and fault outputs.

---
 rtl/bridge_sequencer_pkg.sv | 55 +++++
 rtl/bridge_sequencer_if.sv | 36 +++
 rtl/bridge_sequencer_gate_deadtime.sv | 44 ++++
 rtl/bridge_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_bridge_sequencer.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/bridge_sequencer_pkg.sv
// Shared types for the H-bridge sequencer: command codes, FSM states,
// gate patterns and the command-to-pattern mapping.
package bridge_pkg;

    typedef enum logic [2:0] {
        CMD_PAUSE = 3'd0,
        CMD_PLUS  = 3'd1,
        CMD_MINUS = 3'd2,
        CMD_BAL_P = 3'd3,
        CMD_BAL_N = 3'd4,
        CMD_START = 3'd5,
        CMD_STOP  = 3'd6,
        CMD_DISCH = 3'd7
    } cmd_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PRECH   = 3'd1,
        OVERLAP = 3'd2,
        RUN     = 3'd3,
        DISCH   = 3'd4,
        FAULT   = 3'd5
    } state_e;

    typedef struct packed {
        logic [4:1] top;
        logic [4:1] bot;
    } pattern_t;

    localparam pattern_t PAT_PAUSE = '{top: 4'b0000, bot: 4'b0000};
    localparam pattern_t PAT_PLUS  = '{top: 4'b0001, bot: 4'b0010};
    localparam pattern_t PAT_MINUS = '{top: 4'b0010, bot: 4'b0001};
    localparam pattern_t PAT_BAL_P = '{top: 4'b0100, bot: 4'b1000};
    localparam pattern_t PAT_BAL_N = '{top: 4'b1000, bot: 4'b0100};

    // Discharge arm progress: number of sequence steps (7,0,7,0) already seen.
    localparam int ARM_W = 3;

    function automatic pattern_t cmd_to_pattern(input cmd_e c);
        case (c)
            CMD_PLUS:  return PAT_PLUS;
            CMD_MINUS: return PAT_MINUS;
            CMD_BAL_P: return PAT_BAL_P;
            CMD_BAL_N: return PAT_BAL_N;
            default:   return PAT_PAUSE;
        endcase
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/bridge_sequencer_if.sv
// Board-side bundle of the sequencer: strobed command bus, error pins,
// gate/contactor outputs and status for the UART reporter.
interface bridge_sequencer_if;
    logic       cmd_strobe;
    logic [2:0] cmd;
    logic [4:1] err_dr_n;
    logic       err_i_n;
    logic       err_u_n;
    logic       stop_k_n;

    logic [4:1] top;
    logic [4:1] bot;
    logic       plus;
    logic       minus;
    logic       pause_p;
    logic       pause_n;
    logic       fan;
    logic       charge;
    logic       st;
    logic       td;
    logic       fault;
    logic [4:1] erbd;
    logic [2:0] state;

    modport master (
        output cmd_strobe, cmd, err_dr_n, err_i_n, err_u_n, stop_k_n,
        input  top, bot, plus, minus, pause_p, pause_n,
        input  fan, charge, st, td, fault, erbd, state
    );

    modport slave (
        input  cmd_strobe, cmd, err_dr_n, err_i_n, err_u_n, stop_k_n,
        output top, bot, plus, minus, pause_p, pause_n,
        output fan, charge, st, td, fault, erbd, state
    );
endinterface

// File: rtl/bridge_sequencer_gate_deadtime.sv
// Turns a requested gate pattern into the applied one, inserting DEAD_CYC
// all-off cycles between differing non-pause patterns.
module gate_deadtime
    import bridge_pkg::*;
#(
    parameter int DEAD_CYC = 50
) (
    input  logic     clk,
    input  logic     rst_n,
    input  pattern_t target,
    input  logic     force_off,
    output pattern_t applied
);
    localparam int CNT_W = $clog2(DEAD_CYC + 1);

    logic [CNT_W-1:0] cnt;
    logic             in_dead;

    // A retarget during dead time just updates target; cnt keeps running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            applied <= PAT_PAUSE;
            cnt     <= '0;
            in_dead <= 1'b0;
        end else if (force_off || target == PAT_PAUSE) begin
            applied <= PAT_PAUSE;
            cnt     <= '0;
            in_dead <= 1'b0;
        end else if (in_dead) begin
            if (cnt == CNT_W'(DEAD_CYC - 1)) begin
                applied <= target;
                cnt     <= '0;
                in_dead <= 1'b0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else if (target != applied) begin
            applied <= PAT_PAUSE;
            cnt     <= '0;
            in_dead <= 1'b1;
        end
    end

endmodule

// File: rtl/bridge_sequencer.sv
// H-bridge controller: synchronizes the command/error pins, runs the
// precharge / run / discharge / fault FSM and drives gates via dead-time logic.
module bridge_sequencer
    import bridge_pkg::*;
#(
    parameter int FREQ       = 50_000_000,
    parameter int DEAD_CYC   = 50,
    parameter int CHARGE_MS  = 15000,
    parameter int OVERLAP_MS = 1000,
    parameter int DISCH_MS   = 2000
) (
    input logic               clk,
    input logic               rst_n,
    bridge_sequencer_if.slave bus
);
    localparam int PRESC   = FREQ / 1000;
    localparam int PRESC_W = $clog2(PRESC + 1);
    localparam int MAX_MS  = max3(CHARGE_MS, OVERLAP_MS, DISCH_MS);
    localparam int MS_W    = $clog2(MAX_MS + 1);
    localparam int SYNC_W  = 11;
    // Error pins idle high, so the synchronizers come out of reset inactive.
    localparam logic [SYNC_W-1:0] SYNC_IDLE = {1'b0, 3'b000, 4'b1111, 3'b111};

    logic [SYNC_W-1:0] sync1, sync2;
    logic              strobe_s, strobe_prev;
    logic [2:0]        cmd_s;
    logic [4:1]        err_dr_s;
    logic              err_i_s, err_u_s, stop_s;
    logic              err_any;

    logic              cmd_vld;
    cmd_e              cmd_q;

    logic [PRESC_W-1:0] presc;
    logic [MS_W-1:0]    ms_cnt;
    logic               tick;

    state_e             state, state_nxt;
    pattern_t           target, target_nxt, applied;
    logic [ARM_W-1:0]   arm, arm_nxt;
    logic               force_off;

    logic               fan_q, charge_q, st_q, td_q, fault_q;
    logic [4:1]         erbd_q;

    assign {strobe_s, cmd_s, err_dr_s, err_i_s, err_u_s, stop_s} = sync2;
    assign err_any = ~(&err_dr_s) | ~err_i_s | ~err_u_s | ~stop_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1       <= SYNC_IDLE;
            sync2       <= SYNC_IDLE;
            strobe_prev <= 1'b0;
        end else begin
            sync1       <= {bus.cmd_strobe, bus.cmd, bus.err_dr_n,
                            bus.err_i_n, bus.err_u_n, bus.stop_k_n};
            sync2       <= sync1;
            strobe_prev <= strobe_s;
        end
    end

    // Captured command is a one-cycle pulse, acted on by the FSM next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_vld <= 1'b0;
            cmd_q   <= CMD_PAUSE;
        end else begin
            cmd_vld <= strobe_s & ~strobe_prev;
            if (strobe_s & ~strobe_prev)
                cmd_q <= cmd_e'(cmd_s);
        end
    end

    assign tick = (presc == PRESC_W'(PRESC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc  <= '0;
            ms_cnt <= '0;
        end else if (state_nxt != state) begin
            presc  <= '0;
            ms_cnt <= '0;
        end else if (tick) begin
            presc  <= '0;
            ms_cnt <= ms_cnt + 1'b1;
        end else begin
            presc  <= presc + 1'b1;
        end
    end

    always_comb begin
        state_nxt  = state;
        target_nxt = target;
        arm_nxt    = '0;
        if (err_any) begin
            state_nxt = FAULT;
        end else begin
            case (state)
                IDLE: begin
                    arm_nxt = arm;
                    if (cmd_vld) begin
                        case (cmd_q)
                            CMD_START: begin
                                state_nxt = PRECH;
                                arm_nxt   = '0;
                            end
                            CMD_DISCH: arm_nxt = (arm == 3'd2) ? 3'd3 : 3'd1;
                            CMD_PAUSE: arm_nxt = (arm == 3'd1) ? 3'd2 :
                                                 (arm == 3'd3) ? 3'd4 : 3'd0;
                            CMD_PLUS, CMD_BAL_P: begin
                                arm_nxt = '0;
                                if (arm == 3'd4) begin
                                    state_nxt  = DISCH;
                                    target_nxt = cmd_to_pattern(cmd_q);
                                end
                            end
                            default: arm_nxt = '0;
                        endcase
                    end
                end
                PRECH: begin
                    if (cmd_vld && cmd_q == CMD_STOP)
                        state_nxt = IDLE;
                    else if (tick && ms_cnt == MS_W'(CHARGE_MS - 1))
                        state_nxt = OVERLAP;
                end
                OVERLAP: begin
                    if (cmd_vld && cmd_q == CMD_STOP)
                        state_nxt = IDLE;
                    else if (tick && ms_cnt == MS_W'(OVERLAP_MS - 1))
                        state_nxt = RUN;
                end
                RUN: begin
                    if (cmd_vld) begin
                        case (cmd_q)
                            CMD_STOP:  state_nxt  = IDLE;
                            CMD_START: target_nxt = target;
                            CMD_DISCH: target_nxt = PAT_PAUSE;
                            default:   target_nxt = cmd_to_pattern(cmd_q);
                        endcase
                    end
                end
                DISCH: begin
                    if ((cmd_vld && cmd_q == CMD_STOP) ||
                        (tick && ms_cnt == MS_W'(DISCH_MS - 1)))
                        state_nxt = IDLE;
                end
                FAULT: begin
                    if (cmd_vld && cmd_q == CMD_STOP)
                        state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
        if (state_nxt == IDLE || state_nxt == FAULT)
            target_nxt = PAT_PAUSE;
    end

    // Stop and fault kill the gates in the same edge, bypassing dead time.
    assign force_off = (state_nxt == IDLE) || (state_nxt == FAULT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            target   <= PAT_PAUSE;
            arm      <= '0;
            fan_q    <= 1'b0;
            charge_q <= 1'b0;
            st_q     <= 1'b0;
            td_q     <= 1'b0;
            fault_q  <= 1'b0;
            erbd_q   <= '0;
        end else begin
            state    <= state_nxt;
            target   <= target_nxt;
            arm      <= arm_nxt;
            charge_q <= (state_nxt == PRECH) || (state_nxt == OVERLAP);
            st_q     <= (state_nxt == OVERLAP) || (state_nxt == RUN);
            td_q     <= (state_nxt == DISCH);
            fault_q  <= (state_nxt == FAULT);
            if (state_nxt == PRECH)
                fan_q <= 1'b1;
            else if (state_nxt == IDLE)
                fan_q <= 1'b0;
            if (state_nxt == FAULT)
                erbd_q <= erbd_q | ~err_dr_s;
            else if (state_nxt == IDLE)
                erbd_q <= '0;
        end
    end

    gate_deadtime #(
        .DEAD_CYC (DEAD_CYC)
    ) u_gate (
        .clk       (clk),
        .rst_n     (rst_n),
        .target    (target_nxt),
        .force_off (force_off),
        .applied   (applied)
    );

    assign bus.top     = applied.top;
    assign bus.bot     = applied.bot;
    assign bus.plus    = (applied == PAT_PLUS);
    assign bus.minus   = (applied == PAT_MINUS);
    assign bus.pause_p = (applied == PAT_BAL_P);
    assign bus.pause_n = (applied == PAT_BAL_N);
    assign bus.fan     = fan_q;
    assign bus.charge  = charge_q;
    assign bus.st      = st_q;
    assign bus.td      = td_q;
    assign bus.fault   = fault_q;
    assign bus.erbd    = erbd_q;
    assign bus.state   = state;

endmodule

// File: tb/tb_bridge_sequencer.sv
// Directed bench for bridge_sequencer with 50-cycle ms ticks and short timers.
module tb_bridge_sequencer;

    localparam int DEAD = 50;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   eff = 0;
    int   n_cmp = 0;
    int   n_mis = 0;
    int   zcnt = 0;
    int   last_gap = -1;
    logic mon_en = 1'b0;

    int seq_arm_bp [5] = '{7, 0, 7, 0, 3};
    int seq_broken [6] = '{7, 0, 7, 0, 2, 1};
    int seq_plus   [8] = '{7, 0, 2, 7, 0, 7, 0, 1};

    bridge_sequencer_if bus ();

    bridge_sequencer #(
        .FREQ       (50_000),
        .DEAD_CYC   (DEAD),
        .CHARGE_MS  (15),
        .OVERLAP_MS (1),
        .DISCH_MS   (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic chk_gates(input string tag, input logic [3:0] t, input logic [3:0] b);
        chk({tag, ".top"}, 32'(bus.top), 32'(t));
        chk({tag, ".bot"}, 32'(bus.bot), 32'(b));
    endtask

    // Raise strobe with cmd; returns #1 after the edge at which the command acts.
    task automatic issue(input int c);
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus.cmd        = 3'(c);
        bus.cmd_strobe = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        eff            = cyc;
        bus.cmd_strobe = 1'b0;
    endtask

    task automatic wait_to(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Shoot-through check every cycle, plus length of the last all-off gap.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("no_shoot_through", 32'(bus.top & bus.bot), 32'd0);
                if ((bus.top | bus.bot) != 4'b0000) begin
                    if (zcnt != 0) last_gap = zcnt;
                    zcnt = 0;
                end else begin
                    zcnt = zcnt + 1;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        rst_n          = 1'b0;
        bus.cmd_strobe = 1'b0;
        bus.cmd        = 3'd0;
        bus.err_dr_n   = 4'b1111;
        bus.err_i_n    = 1'b1;
        bus.err_u_n    = 1'b1;
        bus.stop_k_n   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.state", 32'(bus.state), 32'd0);
        chk_gates("rst", 4'b0000, 4'b0000);
        chk("rst.outs", 32'({bus.fan, bus.charge, bus.st, bus.td, bus.fault}), 32'd0);
        chk("rst.ind", 32'({bus.plus, bus.minus, bus.pause_p, bus.pause_n}), 32'd0);
        chk("rst.erbd", 32'(bus.erbd), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Precharge: PRECH entry at eff, st at +750, RUN at +800.
        issue(5);
        begin
            int e;
            e = eff;
            chk("prech.state", 32'(bus.state), 32'd1);
            chk("prech.fan_chg_st", 32'({bus.fan, bus.charge, bus.st}), 32'b110);
            issue(0);
            wait_to(e + 749);
            chk("prech.st_before", 32'(bus.st), 32'd0);
            wait_to(e + 750);
            chk("ovl.st_chg", 32'({bus.st, bus.charge}), 32'b11);
            chk("ovl.state", 32'(bus.state), 32'd2);
            wait_to(e + 799);
            chk("ovl.chg_before", 32'(bus.charge), 32'd1);
            wait_to(e + 800);
            chk("run.st_chg", 32'({bus.st, bus.charge}), 32'b10);
            chk("run.state", 32'(bus.state), 32'd3);
        end

        mon_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            int e;
            last_gap = -1;
            issue((i % 2 == 0) ? 1 : 2);
            e = eff;
            chk_gates("alt.gap_start", 4'b0000, 4'b0000);
            wait_to(e + DEAD - 1);
            chk_gates("alt.gap_end", 4'b0000, 4'b0000);
            wait_to(e + DEAD);
            if (i % 2 == 0) chk_gates("alt.plus", 4'b0001, 4'b0010);
            else            chk_gates("alt.minus", 4'b0010, 4'b0001);
            wait_to(e + DEAD + 1);
            if (i > 0) chk("alt.gap_len", 32'(last_gap), 32'(DEAD));
        end

        // Retarget inside dead time: one gap from the first command's edge.
        begin
            int e;
            last_gap = -1;
            issue(1);
            e = eff;
            issue(2);
            wait_to(e + DEAD - 1);
            chk_gates("retgt.gap", 4'b0000, 4'b0000);
            wait_to(e + DEAD);
            chk_gates("retgt.final", 4'b0010, 4'b0001);
            chk("retgt.minus_ind", 32'(bus.minus), 32'd1);
            wait_to(e + DEAD + 1);
            chk("retgt.gap_len", 32'(last_gap), 32'(DEAD));
        end

        issue(7);
        chk_gates("run.cmd7_immediate", 4'b0000, 4'b0000);
        issue(5);
        chk("run.cmd5_ignored", 32'(bus.state), 32'd3);

        issue(1);
        wait_to(eff + DEAD);
        chk_gates("run.plus", 4'b0001, 4'b0010);
        chk("run.plus_ind", 32'(bus.plus), 32'd1);

        // Driver error on leg 3 while PLUS is applied.
        @(negedge clk);
        bus.err_dr_n = 4'b1011;
        repeat (3) @(posedge clk);
        #1;
        chk_gates("fault.gates", 4'b0000, 4'b0000);
        chk("fault.flag", 32'(bus.fault), 32'd1);
        chk("fault.erbd", 32'(bus.erbd), 32'b0100);
        chk("fault.state", 32'(bus.state), 32'd5);
        chk("fault.fan_chg_st_td", 32'({bus.fan, bus.charge, bus.st, bus.td}), 32'b1000);
        issue(6);
        chk("fault.stop_while_err", 32'(bus.state), 32'd5);
        chk("fault.still_flag", 32'(bus.fault), 32'd1);
        @(negedge clk);
        bus.err_dr_n = 4'b1111;
        repeat (5) @(posedge clk);
        #1;
        chk("fault.latched", 32'({bus.fault, bus.erbd}), 32'b10100);
        issue(6);
        chk("clear.state", 32'(bus.state), 32'd0);
        chk("clear.fault_erbd_fan", 32'({bus.fault, bus.erbd, bus.fan}), 32'd0);

        // Armed discharge into BAL_P.
        for (int i = 0; i < 5; i++) begin
            issue(seq_arm_bp[i]);
            if (i < 4) chk("arm.idle", 32'(bus.state), 32'd0);
        end
        begin
            int e;
            e = eff;
            chk("disch.state_td", 32'({bus.state, bus.td}), 32'b1001);
            wait_to(e + DEAD - 1);
            chk_gates("disch.gap", 4'b0000, 4'b0000);
            wait_to(e + DEAD);
            chk_gates("disch.balp", 4'b0100, 4'b1000);
            chk("disch.pause_p", 32'(bus.pause_p), 32'd1);
            wait_to(e + 99);
            chk("disch.td_held", 32'(bus.td), 32'd1);
            wait_to(e + 100);
            chk("disch.end_state_td", 32'({bus.state, bus.td}), 32'd0);
            chk_gates("disch.end", 4'b0000, 4'b0000);
        end

        for (int i = 0; i < 6; i++) issue(seq_broken[i]);
        chk("arm.broken", 32'(bus.state), 32'd0);

        for (int i = 0; i < 8; i++) issue(seq_plus[i]);
        chk("arm2.state", 32'(bus.state), 32'd4);
        wait_to(eff + DEAD);
        chk_gates("arm2.plus", 4'b0001, 4'b0010);
        chk("arm2.td", 32'(bus.td), 32'd1);
        issue(6);
        chk("abort.state_td", 32'({bus.state, bus.td}), 32'd0);
        chk_gates("abort", 4'b0000, 4'b0000);

        // Asynchronous reset in the middle of OVERLAP.
        issue(5);
        wait_to(eff + 770);
        chk("ovl2.state", 32'(bus.state), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.outs", 32'({bus.fan, bus.charge, bus.st, bus.td, bus.fault}), 32'd0);
        chk("arst.state", 32'(bus.state), 32'd0);
        chk_gates("arst", 4'b0000, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        issue(5);
        begin
            int e;
            e = eff;
            wait_to(e + 749);
            chk("restart.prech", 32'({bus.state, bus.st}), 32'b0010);
            wait_to(e + 750);
            chk("restart.ovl", 32'({bus.state, bus.st}), 32'b0101);
            wait_to(e + 800);
            chk("restart.run", 32'({bus.state, bus.charge}), 32'b0110);
        end
        issue(2);
        wait_to(eff + DEAD);
        chk_gates("run2.minus", 4'b0010, 4'b0001);
        issue(6);
        chk("stop.state", 32'(bus.state), 32'd0);
        chk_gates("stop", 4'b0000, 4'b0000);
        chk("stop.outs", 32'({bus.fan, bus.charge, bus.st, bus.td}), 32'd0);

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
